// File: rtl/winograd_tile_scheduler_pkg.sv
// Shared types and constants for the polyphase Winograd tile scheduler.
// Indices are at least one bit wide so that degenerate 1-tile images still elaborate.
package winograd_pkg;

   typedef enum logic [2:0] {IDLE, KLOAD, ISSUE, DRAIN, DONE} sched_state_t;
   typedef enum logic [1:0] {PH_EE, PH_EO, PH_OE, PH_OO} phase_t;

   localparam int unsigned TILE_OUT = 2;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/winograd_tile_scheduler_if.sv
// Job-issue and result-return handshake between the tile scheduler and the shared engine.
interface winograd_tile_scheduler_if
   import winograd_pkg::*;
#(
   parameter int unsigned ROW_W = 1,
   parameter int unsigned COL_W = 1
);

   logic             issue_valid;
   logic             issue_ready;
   logic [ROW_W-1:0] issue_tile_row;
   logic [COL_W-1:0] issue_tile_col;
   phase_t           issue_phase;
   logic             issue_first;
   logic             issue_last;
   logic             res_valid;

   modport master (
      output issue_valid,
      output issue_tile_row,
      output issue_tile_col,
      output issue_phase,
      output issue_first,
      output issue_last,
      input  issue_ready,
      input  res_valid
   );

   modport slave (
      input  issue_valid,
      input  issue_tile_row,
      input  issue_tile_col,
      input  issue_phase,
      input  issue_first,
      input  issue_last,
      output issue_ready,
      output res_valid
   );

endinterface

// File: rtl/winograd_tile_scheduler_counter.sv
// Nested job counter: phase innermost, then tile column, then tile row.
// wrap flags the final job of the image; advancing past it returns to (0,0,0).
module winograd_tile_counter
   import winograd_pkg::*;
#(
   parameter int unsigned TR    = 56,
   parameter int unsigned TC    = 56,
   parameter int unsigned ROW_W = 6,
   parameter int unsigned COL_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output phase_t           phase,
   output logic             first,
   output logic             last,
   output logic             wrap
);

   logic row_max;
   logic col_max;

   assign row_max = (row == ROW_W'(TR - 1));
   assign col_max = (col == COL_W'(TC - 1));
   assign first   = (phase == PH_EE);
   assign last    = (phase == PH_OO);
   assign wrap    = last && col_max && row_max;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row   <= '0;
         col   <= '0;
         phase <= PH_EE;
      end else if (advance) begin
         phase <= phase_t'(phase + 2'd1);
         if (last) begin
            if (col_max) begin
               col <= '0;
               row <= row_max ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/winograd_tile_scheduler.sv
// Time-multiplexes one F(2x2,3x3) Winograd engine over the four polyphase sub-images,
// issuing tile jobs under a credit limit and signalling completion once all results return.
module winograd_tile_scheduler
   import winograd_pkg::*;
#(
   parameter int unsigned rows      = 224,
   parameter int unsigned cols      = 224,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      divide_done,
   output logic                      kt_start,
   input  logic                      kt_done,
   winograd_tile_scheduler_if.master eng,
   output logic                      busy,
   output logic                      Convolution_done,
   output logic                      err_spurious
);

   localparam int unsigned TR    = rows / (2 * TILE_OUT);
   localparam int unsigned TC    = cols / (2 * TILE_OUT);
   localparam int unsigned ROW_W = idx_width(TR);
   localparam int unsigned COL_W = idx_width(TC);

   sched_state_t state;
   logic [3:0]   outst;
   logic         credit_ok;
   logic         accept;
   logic         res_ok;
   logic         wrap;
   logic         ctr_clear;

   // Credit check deliberately uses the pre-update count, so a same-cycle return frees no slot.
   assign credit_ok       = (outst < 4'(MAX_OUTST));
   assign eng.issue_valid = (state == ISSUE) && credit_ok;
   assign accept          = eng.issue_valid && eng.issue_ready;
   assign res_ok          = eng.res_valid && (outst != '0);
   assign busy            = (state != IDLE);
   assign ctr_clear       = (state == IDLE) && divide_done;

   winograd_tile_counter #(
      .TR    (TR),
      .TC    (TC),
      .ROW_W (ROW_W),
      .COL_W (COL_W)
   ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (ctr_clear),
      .advance (accept),
      .row     (eng.issue_tile_row),
      .col     (eng.issue_tile_col),
      .phase   (eng.issue_phase),
      .first   (eng.issue_first),
      .last    (eng.issue_last),
      .wrap    (wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         kt_start         <= 1'b0;
         Convolution_done <= 1'b0;
      end else begin
         kt_start         <= 1'b0;
         Convolution_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (divide_done) begin
                  state    <= KLOAD;
                  kt_start <= 1'b1;
               end
            end
            KLOAD: begin
               if (kt_done) state <= ISSUE;
            end
            ISSUE: begin
               if (accept && wrap) state <= DRAIN;
            end
            DRAIN: begin
               if (outst == '0) begin
                  state            <= DONE;
                  Convolution_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A return with nothing outstanding is flagged but never underflows the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         outst        <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (accept && !res_ok) begin
            outst <= outst + 4'd1;
         end else if (!accept && res_ok) begin
            outst <= outst - 4'd1;
         end
         if (eng.res_valid && (outst == '0)) err_spurious <= 1'b1;
      end
   end

endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Scoreboard bench: the driver queues expected jobs, a negedge monitor checks every cycle
// against a job-level reference model of the scheduler's observable behaviour.
module tb_winograd_tile_scheduler;
   import winograd_pkg::*;

   localparam int ROWS      = 8;
   localparam int COLS      = 8;
   localparam int MAX_OUTST = 4;
   localparam int TR        = ROWS / 4;
   localparam int TC        = COLS / 4;
   localparam int TOTAL     = 4 * TR * TC;
   localparam int RET_LAT   = 5;

   typedef struct {
      int row;
      int col;
      int ph;
   } job_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic divide_done = 1'b0;
   logic kt_done = 1'b0;
   logic kt_start;
   logic busy;
   logic Convolution_done;
   logic err_spurious;

   winograd_tile_scheduler_if #(
      .ROW_W (idx_width(TR)),
      .COL_W (idx_width(TC))
   ) eng ();

   winograd_tile_scheduler #(
      .rows      (ROWS),
      .cols      (COLS),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .divide_done      (divide_done),
      .kt_start         (kt_start),
      .kt_done          (kt_done),
      .eng              (eng),
      .busy             (busy),
      .Convolution_done (Convolution_done),
      .err_spurious     (err_spurious)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   job_t exp_q[$];
   int   pending[$];

   // Reference model state
   int running   = 0;
   int waiting   = 0;
   int issuing   = 0;
   int ref_outst = 0;
   int err_m     = 0;
   int kt_cyc    = -1;
   int done_cyc  = -1;
   int acc_run   = 0;
   int done_cnt  = 0;

   // Driver controls
   bit auto_res  = 0;
   bit res_pulse = 0;
   bit div_pulse = 0;
   bit kt_pulse  = 0;
   bit bp_mode   = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      job_t j;
      int   acc;
      int   dec;
      if (rst) begin
         running   = 0;
         waiting   = 0;
         issuing   = 0;
         ref_outst = 0;
         err_m     = 0;
         kt_cyc    = -1;
         done_cyc  = -1;
         acc_run   = 0;
         exp_q.delete();
         pending.delete();
      end else begin
         chk("kt_start", int'(kt_start), int'(cyc == kt_cyc));
         chk("busy", int'(busy), running);
         chk("issue_valid", int'(eng.issue_valid), int'(issuing != 0 && ref_outst < MAX_OUTST));
         chk("conv_done", int'(Convolution_done), int'(cyc == done_cyc));
         chk("err_spurious", int'(err_spurious), err_m);
         acc = int'(eng.issue_valid && eng.issue_ready);
         dec = int'(eng.res_valid && ref_outst > 0);
         if (acc != 0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_job at cycle %0d: got an accept, required none", cyc);
            end else begin
               j = exp_q.pop_front();
               chk("job_row", int'(eng.issue_tile_row), j.row);
               chk("job_col", int'(eng.issue_tile_col), j.col);
               chk("job_phase", int'(eng.issue_phase), j.ph);
               chk("job_first", int'(eng.issue_first), int'(j.ph == 0));
               chk("job_last", int'(eng.issue_last), int'(j.ph == 3));
            end
            acc_run++;
            pending.push_back(cyc + RET_LAT);
            if (acc_run == TOTAL) issuing = 0;
         end
         if (eng.res_valid && ref_outst == 0) err_m = 1;
         ref_outst = ref_outst + acc - dec;
         if (dec != 0 && ref_outst == 0 && acc_run == TOTAL && running != 0 && issuing == 0)
            done_cyc = cyc + 2;
         if (divide_done && running == 0) begin
            running = 1;
            waiting = 1;
            kt_cyc  = cyc + 1;
            acc_run = 0;
         end
         if (kt_done && waiting != 0 && cyc >= kt_cyc) begin
            waiting = 0;
            issuing = 1;
         end
         if (cyc == done_cyc) begin
            running = 0;
            done_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (res_pulse || (auto_res && pending.size() > 0 && pending[0] <= cyc)) begin
         eng.res_valid = 1'b1;
         if (pending.size() > 0) void'(pending.pop_front());
      end else begin
         eng.res_valid = 1'b0;
      end
      res_pulse   = 0;
      divide_done = div_pulse;
      div_pulse   = 0;
      kt_done     = kt_pulse;
      kt_pulse    = 0;
      if (bp_mode) eng.issue_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
   endtask

   task automatic start_run();
      job_t j;
      for (int r = 0; r < TR; r++)
         for (int c = 0; c < TC; c++)
            for (int p = 0; p < 4; p++) begin
               j.row = r;
               j.col = c;
               j.ph  = p;
               exp_q.push_back(j);
            end
      div_pulse = 1;
      tick();
      tick();
      tick();
      kt_pulse = 1;
      tick();
   endtask

   task automatic wait_done(input int target, input int budget, input string nm);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      chk(nm, done_cnt, target);
   endtask

   task automatic wait_accepts(input int target, input int budget, input string nm);
      int n = 0;
      while (acc_run < target && n < budget) begin
         tick();
         n++;
      end
      chk(nm, acc_run, target);
   endtask

   initial begin
      eng.issue_ready = 1'b0;
      eng.res_valid   = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_valid", int'(eng.issue_valid), 0);
      chk("reset_err", int'(err_spurious), 0);

      // Nominal flow
      eng.issue_ready = 1'b1;
      auto_res = 1;
      start_run();
      wait_done(1, 400, "nominal_done");
      chk("nominal_accepts", acc_run, TOTAL);
      repeat (3) tick();

      // Credit limit, then returns while at the limit
      auto_res = 0;
      start_run();
      repeat (12) tick();
      chk("credit_stall", acc_run, MAX_OUTST);
      res_pulse = 1;
      tick();
      repeat (4) tick();
      chk("credit_refill", acc_run, MAX_OUTST + 1);
      res_pulse = 1;
      tick();
      repeat (3) tick();
      chk("credit_refill2", acc_run, MAX_OUTST + 2);

      // Backpressure for the rest of the run
      bp_mode  = 1;
      auto_res = 1;
      wait_done(2, 600, "backpressure_done");
      bp_mode = 0;
      eng.issue_ready = 1'b1;

      // Spurious return in IDLE and ignored divide_done mid-run
      repeat (2) tick();
      res_pulse = 1;
      tick();
      tick();
      chk("spurious_set", int'(err_spurious), 1);
      start_run();
      wait_accepts(5, 100, "ignored_div_reach");
      div_pulse = 1;
      tick();
      wait_done(3, 400, "ignored_div_done");
      chk("spurious_sticky", int'(err_spurious), 1);

      // Reset mid-run, then restart from the first job
      start_run();
      wait_accepts(7, 200, "abort_reach");
      auto_res = 0;
      eng.issue_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(eng.issue_valid), 0);
      chk("abort_err", int'(err_spurious), 0);
      eng.issue_ready = 1'b1;
      auto_res = 1;
      start_run();
      wait_done(4, 400, "restart_done");
      chk("restart_accepts", acc_run, TOTAL);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
